// File: rtl/ram_range_reader.sv
// Sweeps a RAM over [firstaddr, lastaddr) with credit-limited pipelined reads and streams the words on valid/ready.
// Optional running checksum of accepted words: define RANGE_READER_CHECKSUM_EN.
module ram_range_reader #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int RAM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              re_RAM,
  input  logic [ADDR_W-1:0] firstaddr,
  input  logic [ADDR_W-1:0] lastaddr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]             state_r, state_s;
  logic [ADDR_W-1:0]      next_addr_r, end_addr_r, issue_addr_s;
  logic [RAM_LATENCY-1:0] vld_r;
  logic [DATA_W-1:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_r, rd_ptr_r, rd_ptr_s;
  logic [CW-1:0]          count_r, count_s, total_r;
  logic [DATA_W-1:0]      head_s;
  logic                   push_s, pop_s, issue_s, accept_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_s   = vld_r[RAM_LATENCY-1];
  assign pop_s    = out_valid && out_ready;
  assign accept_s = (state_r == S_IDLE) && start && re_RAM;

  // Next state and read issue; total_r counts FIFO words plus reads in flight
  always_comb begin
    state_s      = state_r;
    issue_s      = 1'b0;
    issue_addr_s = next_addr_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          issue_addr_s = firstaddr;
          if (lastaddr <= firstaddr) begin
            state_s = S_FINISH;
          end else begin
            issue_s = 1'b1;
            state_s = (firstaddr + ADDR_W'(1) == lastaddr) ? S_DRAIN : S_ISSUE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if ((total_r - CW'(pop_s)) < DEPTH_C) begin
          issue_s = 1'b1;
          state_s = (next_addr_r == end_addr_r - ADDR_W'(1)) ? S_DRAIN : S_ISSUE;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if ((total_r - CW'(pop_s)) == '0) begin
          state_s = S_FINISH;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; head_s is the word at the head after this edge
  always_comb begin
    count_s  = count_r + CW'(push_s) - CW'(pop_s);
    rd_ptr_s = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
    if ((count_r - CW'(pop_s)) == '0) begin
      head_s = ram_q;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Sweep control, RAM read port, return tagging and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      ram_re      <= 1'b0;
      ram_addr    <= '0;
      next_addr_r <= '0;
      end_addr_r  <= '0;
      total_r     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      vld_r       <= '0;
    end else begin
      state_r <= state_s;
      ram_re  <= issue_s;
      if (issue_s) begin
        ram_addr    <= issue_addr_s;
        next_addr_r <= issue_addr_s + ADDR_W'(1);
      end
      if (accept_s) begin
        end_addr_r <= lastaddr;
      end
      total_r  <= total_r + CW'(issue_s) - CW'(pop_s);
      busy     <= (state_s == S_ISSUE) || (state_s == S_DRAIN);
      done     <= (state_s == S_FINISH);
      vld_r[0] <= ram_re;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
    end
  end

  // Output skid FIFO pointers and registered head/valid/index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      rd_ptr_r  <= rd_ptr_s;
      count_r   <= count_s;
      out_valid <= (count_s != '0);
      if (count_s != '0) begin
        out_data <= head_s;
      end
      if (accept_s) begin
        out_index <= '0;
      end else if (pop_s) begin
        out_index <= out_index + ADDR_W'(1);
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= ram_q;
    end
  end

`ifdef RANGE_READER_CHECKSUM_EN
  // Running sum of accepted words, restarted by each accepted sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept_s) begin
      checksum <= '0;
    end else if (pop_s) begin
      checksum <= checksum + out_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/ram_range_reader.md
Name: ram_range_reader

Overview:
- Consumer side of the step-to-address-range decoder.
- Takes one [firstaddr, lastaddr) window with its read-enable, sweeps the weight/picture RAM over that window with pipelined reads, and streams the words downstream on a valid/ready interface.
- Pulses done so the top-level step controller can advance to the next step.

Parameters:
- ADDR_W, 13, width of RAM address and range bounds.
- DATA_W, 16, width of a RAM word.
- RAM_LATENCY, 1, cycles from ram_re/ram_addr to valid ram_q; legal values 1 or 2.
- FIFO_DEPTH, 4, output skid FIFO entries; must be at least RAM_LATENCY+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- re_RAM  in  1  range-valid from the address decoder; start is ignored when 0.
- firstaddr  in  ADDR_W  first address, inclusive.
- lastaddr  in  ADDR_W  end address, exclusive.
- ram_re  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM read address.
- ram_q  in  DATA_W  RAM read data, valid RAM_LATENCY cycles after ram_re.
- out_data  out  DATA_W  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when high together with out_valid.
- out_index  out  ADDR_W  offset of out_data from firstaddr.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- checksum  out  DATA_W  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0) clears all outputs to 0: ram_re, ram_addr, out_valid, out_data, out_index, busy, done, checksum. FSM goes to IDLE, FIFO empties, and any in-flight read data is discarded.
- FSM has four states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE
  - On start=1 and re_RAM=1, latch firstaddr into next_addr and lastaddr into end_addr, set busy=1 on the next cycle, and clear the index counter.
  - If lastaddr<=firstaddr, the range is empty: go to FINISH with no RAM reads.
  - Otherwise go to ISSUE.
  - start with re_RAM=0 is ignored.
- ISSUE
  - Assert ram_re with ram_addr=next_addr when (FIFO occupancy + reads in flight) < FIFO_DEPTH; then increment next_addr.
  - When the read of end_addr-1 is issued, go to DRAIN.
  - Peak rate is one read per clock. Credit accounting guarantees FIFO overflow is impossible under any out_ready pattern.
- Read return: a RAM_LATENCY-stage valid shift register tags each returning ram_q, which is written into the FIFO.
- DRAIN: wait until no reads are in flight and the FIFO is empty (last word accepted), then go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE. A start on the FINISH cycle is ignored.
- Output stream
  - out_valid = FIFO not empty; out_data = FIFO head.
  - On out_valid && out_ready, pop the head and increment out_index.
  - out_index is 0 for the first word and end_addr-firstaddr-1 for the last.
  - out_data and out_index hold while out_valid=1 and out_ready=0.
- start while busy=1 is ignored. Latched bounds are not affected by later changes on firstaddr/lastaddr/re_RAM.
- Word order equals address order. Exactly end_addr-firstaddr words per sweep.
- Address arithmetic is unsigned ADDR_W. A range ending at 2^ADDR_W-1 must not wrap: the compare uses end_addr, not next_addr overflow.
- Latency: first ram_re 1 cycle after accepted start. First out_valid RAM_LATENCY+1 cycles after that ram_re (1 cycle FIFO write).
- Simultaneous FIFO push and pop with the FIFO full or empty is legal; occupancy stays consistent.

Optional Feature:
- Macro RANGE_READER_CHECKSUM_EN.
- Defined:
  - checksum accumulates the modulo-2^DATA_W sum of every word accepted on the output (out_valid && out_ready).
  - It clears on an accepted start and holds its final value from the done pulse until the next accepted start.
- Undefined: checksum is tied to 0 and no accumulator logic exists.

Test Plan:
- Reset mid-sweep: firstaddr=784, lastaddr=820, deassert rst_n after 10 words with out_ready=1 -> all outputs 0 immediately. Then a new start with firstaddr=0, lastaddr=3 delivers exactly 3 words at index 0,1,2 and no stale data.
- Basic sweep: RAM model q=addr, firstaddr=784, lastaddr=820, out_ready=1 -> out_data 784..819 back-to-back, out_index 0..35, done one cycle after the last accept, 36 ram_re total.
- Backpressure: same range, out_ready toggling 1,0,0,1 pattern -> identical data sequence, no drops/duplicates, FIFO occupancy never exceeds 4, held out_data stable while stalled.
- Empty and ignored starts: firstaddr=lastaddr=900 -> done within 2 cycles, zero ram_re. start with re_RAM=0 -> no activity. start while busy -> no effect on the current sweep.
- Top-of-space range with RAM_LATENCY=2: firstaddr=8188, lastaddr=8191 -> words 8188,8189,8190, no wrap to address 0.
- RANGE_READER_CHECKSUM_EN defined, q=addr, range 0..4 -> checksum=6 at the done pulse. Next accepted start clears it to 0.
